// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing controller for the 5-stage core.
// Detects load-use hazards, taken-branch redirects and data-memory waits, and
// drives the PC / pipeline-register enables, bubble and flush controls. It also
// keeps saturating stall/flush counters and a sticky memory-timeout flag.
//
// Ports:
//   clk, arst_n                     clock, asynchronous active-low reset
//   memread_IDEX, register_rd_IDEX  load in EX and its destination register
//   register_rs1/rs2_IFID, uses_*   source registers read by the ID instruction
//   branch_taken_EXMEM              taken branch/jump resolved in MEM
//   dmem_req_EXMEM, dmem_ready      MEM-stage data access and its completion
//   pc_write, *_write               PC and pipeline-register write enables
//   idex_bubble, memwb_bubble       insert NOP control into ID/EX, MEM/WB
//   *_flush                         clear IF/ID, ID/EX, EX/MEM
//   stall_cycles, flush_count       saturating performance counters
//   mem_timeout                     sticky: a single wait hit TIMEOUT_CYCLES
//   ctrl_state                      0 RUN, 1 LOAD_STALL, 2 MEM_WAIT
module hazard_controller #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 memread_IDEX,
  input  logic [4:0]           register_rd_IDEX,
  input  logic [4:0]           register_rs1_IFID,
  input  logic [4:0]           register_rs2_IFID,
  input  logic                 uses_rs1_IFID,
  input  logic                 uses_rs2_IFID,
  input  logic                 branch_taken_EXMEM,
  input  logic                 dmem_req_EXMEM,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_write,
  output logic                 exmem_write,
  output logic                 idex_bubble,
  output logic                 memwb_bubble,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic                 mem_timeout,
  output logic [1:0]           ctrl_state
);

  localparam logic [1:0] StRun       = 2'd0;
  localparam logic [1:0] StLoadStall = 2'd1;
  localparam logic [1:0] StMemWait   = 2'd2;

  localparam logic [3:0]  LuRemaining = 4'(LOAD_USE_CYCLES - 1);
  localparam logic [16:0] TimeoutLim  = 17'(TIMEOUT_CYCLES);

  logic [1:0]           state_q, state_d;
  logic [1:0]           ret_q, ret_d;
  logic [3:0]           rem_q, rem_d;
  logic [15:0]          wait_q, wait_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  logic                 timeout_q, timeout_d;

  logic       memwait, loaduse, branch_evt;
  logic [1:0] eff_state;
  logic [16:0] wait_inc;

  assign memwait = dmem_req_EXMEM & ~dmem_ready;
  assign loaduse = memread_IDEX & (register_rd_IDEX != 5'd0) &
                   ((uses_rs1_IFID & (register_rd_IDEX == register_rs1_IFID)) |
                    (uses_rs2_IFID & (register_rd_IDEX == register_rs2_IFID)));

  // While waiting, the saved return state decides behaviour once the wait ends.
  assign eff_state = (state_q == StMemWait) ? ret_q : state_q;
  assign wait_inc  = {1'b0, wait_q} + 17'd1;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    ctrl_state   = eff_state;
    branch_evt   = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    rem_d        = rem_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;

    if (memwait) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      ctrl_state   = StMemWait;
      state_d      = StMemWait;
      if (state_q != StMemWait) ret_d = state_q;
      // Counter saturates at the limit so very long waits cannot wrap.
      if (wait_inc >= TimeoutLim) begin
        timeout_d = 1'b1;
        wait_d    = TimeoutLim[15:0];
      end else begin
        wait_d = wait_inc[15:0];
      end
    end else begin
      wait_d = '0;
      ret_d  = StRun;
      if (branch_taken_EXMEM) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        branch_evt  = 1'b1;
        state_d     = StRun;
        rem_d       = '0;
      end else if (eff_state == StLoadStall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        rem_d       = (rem_q == 4'd0) ? 4'd0 : rem_q - 4'd1;
        state_d     = (rem_q <= 4'd1) ? StRun : StLoadStall;
      end else if (loaduse) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (LuRemaining != 4'd0) begin
          state_d = StLoadStall;
          rem_d   = LuRemaining;
        end else begin
          state_d = StRun;
        end
      end else begin
        state_d = StRun;
      end
    end

    // Reset forces the safe "hold everything, inject NOPs" pattern immediately.
    if (!arst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      ctrl_state   = StRun;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (branch_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StRun;
      ret_q     <= StRun;
      rem_q     <= '0;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances share one stimulus stream
// (A: 1 load-use cycle, timeout 8, 32-bit counters; B: 3 load-use cycles,
// timeout 255, 4-bit counters). A per-cycle reference model tracks owed stall
// cycles, wait length and counters; literal checks pin key points.
module tb_hazard_controller;

  logic       clk, arst_n;
  logic       mr, u1, u2, br, req, rdy;
  logic [4:0] rd, rs1, rs2;

  logic [8:0]  c1, c3;   // {pc,ifid,idex,exmem,idex_bub,memwb_bub,ifid_fl,idex_fl,exmem_fl}
  logic [1:0]  cs1, cs3;
  logic [31:0] sc1, fc1;
  logic [3:0]  sc3, fc3;
  logic        to1, to3;

  int checks = 0;
  int errors = 0;

  hazard_controller #(.LOAD_USE_CYCLES(1), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .arst_n(arst_n), .memread_IDEX(mr), .register_rd_IDEX(rd),
    .register_rs1_IFID(rs1), .register_rs2_IFID(rs2), .uses_rs1_IFID(u1),
    .uses_rs2_IFID(u2), .branch_taken_EXMEM(br), .dmem_req_EXMEM(req), .dmem_ready(rdy),
    .pc_write(c1[8]), .ifid_write(c1[7]), .idex_write(c1[6]), .exmem_write(c1[5]),
    .idex_bubble(c1[4]), .memwb_bubble(c1[3]), .ifid_flush(c1[2]), .idex_flush(c1[1]),
    .exmem_flush(c1[0]), .stall_cycles(sc1), .flush_count(fc1), .mem_timeout(to1),
    .ctrl_state(cs1)
  );

  hazard_controller #(.LOAD_USE_CYCLES(3), .TIMEOUT_CYCLES(255), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .arst_n(arst_n), .memread_IDEX(mr), .register_rd_IDEX(rd),
    .register_rs1_IFID(rs1), .register_rs2_IFID(rs2), .uses_rs1_IFID(u1),
    .uses_rs2_IFID(u2), .branch_taken_EXMEM(br), .dmem_req_EXMEM(req), .dmem_ready(rdy),
    .pc_write(c3[8]), .ifid_write(c3[7]), .idex_write(c3[6]), .exmem_write(c3[5]),
    .idex_bubble(c3[4]), .memwb_bubble(c3[3]), .ifid_flush(c3[2]), .idex_flush(c3[1]),
    .exmem_flush(c3[0]), .stall_cycles(sc3), .flush_count(fc3), .mem_timeout(to3),
    .ctrl_state(cs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: stall debt owed after the current cycle, wait length, counters.
  int     luc[2]  = '{1, 3};
  int     tmo[2]  = '{8, 255};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int     owed[2], wlen[2];
  bit     tflag[2];
  longint stallc[2], flushc[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [8:0]  act_c, exp_c;
      logic [1:0]  act_s, exp_s;
      logic [31:0] act_sc, act_fc;
      logic        act_to, mw, lu;
      if (k == 0) begin
        act_c = c1; act_s = cs1; act_sc = sc1; act_fc = fc1; act_to = to1;
      end else begin
        act_c = c3; act_s = cs3; act_sc = {28'd0, sc3}; act_fc = {28'd0, fc3}; act_to = to3;
      end
      mw = req && !rdy;
      lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      if (!arst_n) begin
        owed[k] = 0; wlen[k] = 0; tflag[k] = 0; stallc[k] = 0; flushc[k] = 0;
        exp_c = 9'b0000_11_000;
        exp_s = 2'd0;
      end else if (mw) begin
        exp_c = 9'b0000_01_000;
        exp_s = 2'd2;
      end else begin
        exp_s = (owed[k] > 0) ? 2'd1 : 2'd0;
        if (br)                     exp_c = 9'b1111_00_111;
        else if (owed[k] > 0 || lu) exp_c = 9'b0011_10_000;
        else                        exp_c = 9'b1111_00_000;
      end
      check($sformatf("dut%0d controls", k), {23'd0, act_c}, {23'd0, exp_c});
      check($sformatf("dut%0d ctrl_state", k), {30'd0, act_s}, {30'd0, exp_s});
      check($sformatf("dut%0d stall_cycles", k), act_sc, 32'(stallc[k]));
      check($sformatf("dut%0d flush_count", k), act_fc, 32'(flushc[k]));
      check($sformatf("dut%0d mem_timeout", k), {31'd0, act_to}, {31'd0, tflag[k]});
      if (arst_n) begin
        if (mw) begin
          wlen[k]++;
          if (wlen[k] >= tmo[k]) tflag[k] = 1;
        end else begin
          wlen[k] = 0;
          if (br) begin
            owed[k] = 0;
            if (flushc[k] < cmax[k]) flushc[k]++;
          end else if (owed[k] > 0) owed[k]--;
          else if (lu) owed[k] = luc[k] - 1;
        end
        if (!exp_c[8] && stallc[k] < cmax[k]) stallc[k]++;
      end
    end
  end

  task automatic set_in(input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic a1, input logic a2,
                        input logic b, input logic q, input logic y);
    mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; br = b; req = q; rdy = y;
  endtask

  task automatic idle();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic loaduse5();
    set_in(1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    arst_n = 1'b0;
    idle();
    #2;
    check("reset controls", {23'd0, c1}, 32'b0000_11_000);
    check("reset ctrl_state", {30'd0, cs1}, 32'd0);
    tick(2);
    arst_n = 1'b1;
    tick(2);
    check("run controls", {23'd0, c1}, 32'b1111_00_000);
    check("run counters", sc1 + fc1, 32'd0);

    // Load-use on rs2=x5.
    loaduse5();
    #1;
    check("loaduse pc/ifid/bubble", {29'd0, c1[8], c1[7], c1[4]}, 32'b001);
    tick(1);
    idle();
    tick(3);
    check("luc1 stall count", sc1, 32'd1);
    check("luc3 stall count", {28'd0, sc3}, 32'd3);

    // rd = x0 never stalls.
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
    #1;
    check("x0 no stall", {31'd0, c1[8]}, 32'd1);
    tick(1);
    idle();
    tick(1);

    // Branch pulse.
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    #1;
    check("branch flushes", {23'd0, c1}, 32'b1111_00_111);
    tick(1);
    idle();
    tick(1);
    check("flush_count", fc1, 32'd1);

    // Branch in 2nd cycle of a 3-cycle load stall cancels it.
    loaduse5();
    tick(1);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    tick(1);
    idle();
    #1;
    check("branch cancels stall", {30'd0, cs3}, 32'd0);
    tick(2);
    check("luc3 stall after cancel", {28'd0, sc3}, 32'd4);
    check("luc3 flush_count", {28'd0, fc3}, 32'd2);

    // Four-cycle memory wait, ready in the fifth.
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    #1;
    check("wait ctrl_state", {30'd0, cs1}, 32'd2);
    check("wait controls", {23'd0, c1}, 32'b0000_01_000);
    tick(4);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    #1;
    check("ready controls", {23'd0, c1}, 32'b1111_00_000);
    tick(1);
    idle();
    tick(1);
    check("stall after wait", sc1, 32'd6);

    // Wait while dut3 has one load-stall cycle left.
    loaduse5();
    tick(1);
    idle();
    tick(1);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    tick(2);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    #1;
    check("restored stall", {30'd0, cs3, c3[8]}, {29'd0, 3'b010});
    tick(1);
    idle();
    #1;
    check("back to run", {30'd0, cs3, c3[8]}, {29'd0, 3'b001});
    check("luc3 stall total", {28'd0, sc3}, 32'd13);
    tick(1);

    // Timeout on dut1 after 8 wait cycles; sticky after ready.
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    tick(7);
    check("no timeout at 7", {31'd0, to1}, 32'd0);
    tick(1);
    check("timeout at 8", {31'd0, to1}, 32'd1);
    check("still waiting", {30'd0, cs1}, 32'd2);
    tick(2);
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    tick(1);
    idle();
    tick(1);
    check("timeout sticky", {30'd0, to1, to3}, 32'b10);
    check("stall sat", {28'd0, sc3}, 32'd15);
    check("stall 32b", sc1, 32'd19);

    // Asynchronous reset in the middle of dut3's load stall.
    loaduse5();
    tick(1);
    idle();
    #1;
    check("in load stall", {30'd0, cs3}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("async reset controls", {23'd0, c3}, 32'b0000_11_000);
    check("async reset state", {30'd0, cs3}, 32'd0);
    check("async reset timeout", {31'd0, to1}, 32'd0);
    tick(2);
    arst_n = 1'b1;
    tick(1);
    check("restart run", {21'd0, cs3, c3}, {21'd0, 2'd0, 9'b1111_00_000});
    check("restart counters", {24'd0, sc3, fc3}, 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage core: detects load-use hazards, branch/jump redirects and multi-cycle data-memory waits.
- Drives the PC / pipeline-register write enables, bubble and flush controls.
- Sits beside the forwarding unit: it handles every hazard that forwarding cannot resolve and owns the pipeline stall state.
- Also keeps stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
- LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..15).
- TIMEOUT_CYCLES, 255, MEM_WAIT cycles before mem_timeout is set (1..65535).
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- memread_IDEX  in  1  instruction in EX is a load
- register_rd_IDEX  in  5  destination register of the instruction in EX
- register_rs1_IFID  in  5  rs1 of the instruction in ID
- register_rs2_IFID  in  5  rs2 of the instruction in ID
- uses_rs1_IFID  in  1  ID instruction reads rs1
- uses_rs2_IFID  in  1  ID instruction reads rs2
- branch_taken_EXMEM  in  1  taken branch or jump resolved in MEM
- dmem_req_EXMEM  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- idex_write  out  1  ID/EX register enable
- exmem_write  out  1  EX/MEM register enable
- idex_bubble  out  1  load NOP control into ID/EX
- memwb_bubble  out  1  load NOP control into MEM/WB
- ifid_flush  out  1  clear IF/ID
- idex_flush  out  1  clear ID/EX
- exmem_flush  out  1  clear EX/MEM
- stall_cycles  out  CNT_WIDTH  cycles with pc_write=0, saturating
- flush_count  out  CNT_WIDTH  branch redirects taken, saturating
- mem_timeout  out  1  sticky: one MEM_WAIT lasted TIMEOUT_CYCLES
- ctrl_state  out  2  current state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT

Behaviour:
- Reset (arst_n=0, asynchronous):
  - State RUN; internal counters, stall_cycles, flush_count and mem_timeout = 0.
  - Combinational outputs are forced while reset is asserted: pc_write, ifid_write, idex_write, exmem_write = 0; idex_bubble, memwb_bubble = 1; all flushes = 0.
  - Reset mid-stall or mid-wait abandons the operation; the controller restarts in RUN.
- Control outputs are combinational from state and inputs, so a stall takes effect in the detection cycle. State, counters and flags are registered on rising clk.
- Default (RUN, no event): all write enables = 1, bubbles = 0, flushes = 0.
- Hazard terms:
  - memwait = dmem_req_EXMEM & ~dmem_ready
  - loaduse = memread_IDEX & (register_rd_IDEX != 0) & ((uses_rs1_IFID & rd==rs1) | (uses_rs2_IFID & rd==rs2))
  - Register x0 never causes a hazard.
- Priority: memwait > branch_taken_EXMEM > loaduse / LOAD_STALL.
- memwait, any state:
  - All four write enables = 0; memwb_bubble = 1; no flushes.
  - The return state and remaining load-stall count are frozen and restored exactly when the wait ends.
  - Branch and load-use inputs are ignored this cycle; the frozen registers re-present them later.
  - Entering from RUN or LOAD_STALL saves that state as the return state, then goes to MEM_WAIT.
  - The wait counter increments each MEM_WAIT cycle. Reaching TIMEOUT_CYCLES sets mem_timeout, which is cleared only by reset. The controller keeps waiting.
  - A cycle with dmem_ready=1 ends the wait: outputs follow the normal rules for the restored state in that same cycle. The wait counter clears.
- branch_taken_EXMEM (no memwait):
  - pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1, and flush_count increments.
  - Any LOAD_STALL is cancelled; the next state is RUN.
- loaduse in RUN:
  - pc_write=0, ifid_write=0, idex_bubble=1 this cycle.
  - If LOAD_USE_CYCLES>1, go to LOAD_STALL with remaining = LOAD_USE_CYCLES-1.
- LOAD_STALL: same outputs as a load-use stall. remaining decrements each cycle; leaving for RUN happens when it reaches 0 after its last stall cycle.
- stall_cycles increments in every non-reset cycle with pc_write=0. Both counters saturate at all-ones.
- ctrl_state shows MEM_WAIT for every memwait cycle, including the first.

Test Plan:
- Reset, then RUN with no hazards → writes=1, bubbles/flushes=0, counters 0; assert arst_n low mid-LOAD_STALL → outputs forced to reset values immediately, ctrl_state=0.
- Load x5 in EX, ID uses rs2=x5, LOAD_USE_CYCLES=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1. Repeat with rd=x0 → no stall. Repeat with LOAD_USE_CYCLES=3 → exactly 3 stall cycles.
- branch_taken_EXMEM pulse → ifid/idex/exmem_flush=1 for 1 cycle, pc_write=1, flush_count=1. Branch in the 2nd cycle of a 3-cycle LOAD_STALL → flush wins, RUN next, no further stall.
- dmem_req=1 with dmem_ready low for 4 cycles → 4 cycles all writes=0, memwb_bubble=1, ctrl_state=2; ready asserted in the 5th cycle → normal outputs; stall_cycles=4.
- Wait during LOAD_STALL (remaining=1) → after ready, exactly 1 more stall cycle, then RUN.
- TIMEOUT_CYCLES=8, ready withheld 10 cycles → mem_timeout set after 8 MEM_WAIT cycles, still waiting, stays 1 after ready; cleared only by reset.
